// File: rtl/riscv_aes_reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// riscv_aes_pkg
// Shared definitions for the AES register bank:
//   - aes_state_e     : control FSM states (IDLE, RUN, DONE)
//   - CTRL_*          : bit positions inside the CTRL/STATUS word
//   - *_offset()      : base addresses of the data, result and CTRL regions
//                       for a given number of words per block (the key region
//                       always starts at address 0)
// -----------------------------------------------------------------------------
package riscv_aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // CTRL/STATUS bit positions
    localparam int CTRL_BUSY        = 0;  // RO
    localparam int CTRL_DONE        = 1;  // sticky, W1C
    localparam int CTRL_ERR_INVALID = 2;  // W1C
    localparam int CTRL_ERR_WR_BUSY = 3;  // W1C
    localparam int CTRL_IRQ_EN      = 4;  // RW
    localparam int CTRL_START       = 5;  // write 1 = start pulse, reads 0

    function automatic int data_offset(input int nw);
        return nw;
    endfunction

    function automatic int result_offset(input int nw);
        return 2 * nw;
    endfunction

    function automatic int ctrl_offset(input int nw);
        return 3 * nw;
    endfunction

endpackage

// File: rtl/riscv_aes_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// riscv_aes_ctrl_fsm
// Sequencing of one AES operation: IDLE -> RUN -> DONE -> IDLE.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : start request (pin or CTRL start bit)
//   all_valid_i     : every key/data word valid, including a same-cycle write
//   core_done_i     : core completion strobe (only honoured in RUN)
//   busy_o          : registered, high while in RUN
//   done_o          : registered, high for the single DONE cycle
//   core_start_o    : registered, one-cycle pulse on entering RUN
//   err_invalid_o   : combinational strobe, start refused for missing words
//   capture_o       : combinational strobe, latch the core result this edge
// -----------------------------------------------------------------------------
module riscv_aes_ctrl_fsm
    import riscv_aes_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic all_valid_i,
    input  logic core_done_i,
    output logic busy_o,
    output logic done_o,
    output logic core_start_o,
    output logic err_invalid_o,
    output logic capture_o
);

    aes_state_e state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            core_start_o <= 1'b0;
        end else begin
            core_start_o <= 1'b0;
            done_o       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && all_valid_i) begin
                        state_q      <= RUN;
                        busy_o       <= 1'b1;
                        core_start_o <= 1'b1;
                    end
                end
                RUN: begin
                    // Further starts are ignored until the core reports done.
                    if (core_done_i) begin
                        state_q <= DONE;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    assign err_invalid_o = (state_q == IDLE) && start_i && !all_valid_i;
    assign capture_o     = (state_q == RUN) && core_done_i;

endmodule

// File: rtl/riscv_aes_reg_bank.sv
// -----------------------------------------------------------------------------
// riscv_aes_reg_bank
// Memory-mapped register bank in front of an AES core. Holds NUM_WORDS key
// words, NUM_WORDS data words, NUM_WORDS result words and a CTRL/STATUS word.
// Address map: 0..NW-1 key, NW..2NW-1 data, 2NW..3NW-1 result (RO), 3NW CTRL.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   test_en_i                     : allows key words to be read back
//   waddr_i, wdata_i, wen_i       : register write port
//   raddr_i, rdata_o              : register read port, one-cycle latency
//   aes_start_i                   : start pulse
//   busy_o, done_o, irq_o         : status (done_o one cycle, irq_o level)
//   core_key_o, core_data_o       : key/data blocks to the core, word 0 at LSB
//   core_start_o, core_done_i     : core handshake
//   core_result_i                 : result block from the core
// Build option: define AES_KEY_ZEROIZE_EN to wipe key words and key valid
// bits when an operation completes.
// -----------------------------------------------------------------------------
module riscv_aes_reg_bank
    import riscv_aes_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_WORDS  = 4,
    localparam int ADDR_WIDTH = $clog2(3 * NUM_WORDS + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            test_en_i,
    input  logic [ADDR_WIDTH-1:0]           waddr_i,
    input  logic [DATA_WIDTH-1:0]           wdata_i,
    input  logic                            wen_i,
    input  logic [ADDR_WIDTH-1:0]           raddr_i,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    input  logic                            aes_start_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            irq_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] core_key_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0] core_data_o,
    output logic                            core_start_o,
    input  logic                            core_done_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] core_result_i
);

    localparam int IDX_W = $clog2(NUM_WORDS);

    logic [DATA_WIDTH-1:0] key_q    [NUM_WORDS];
    logic [DATA_WIDTH-1:0] data_q   [NUM_WORDS];
    logic [DATA_WIDTH-1:0] result_q [NUM_WORDS];
    logic [NUM_WORDS-1:0]  key_vld_q, data_vld_q;

    logic done_q, err_inv_q, err_wb_q, irq_en_q;
    logic done_nxt, err_inv_nxt, err_wb_nxt, irq_en_nxt;

    logic in_key, in_data, in_ctrl;
    logic key_wr, data_wr, wr_busy_err, ctrl_wr;
    logic start_req, all_valid_nxt;
    logic capture, err_invalid_set;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic [NUM_WORDS-1:0] wr_onehot;
    logic [DATA_WIDTH-1:0] status_word, rd_word;

    // Write decode. Region bases are multiples of NUM_WORDS (a power of two),
    // so the low address bits index the word inside any region.
    always_comb begin
        in_key      = int'(waddr_i) < data_offset(NUM_WORDS);
        in_data     = !in_key && (int'(waddr_i) < result_offset(NUM_WORDS));
        in_ctrl     = int'(waddr_i) == ctrl_offset(NUM_WORDS);
        wr_idx      = waddr_i[IDX_W-1:0];
        key_wr      = wen_i && in_key  && !busy_o;
        data_wr     = wen_i && in_data && !busy_o;
        wr_busy_err = wen_i && (in_key || in_data) && busy_o;
        ctrl_wr     = wen_i && in_ctrl;
        start_req   = aes_start_i || (ctrl_wr && wdata_i[CTRL_START]);

        wr_onehot         = '0;
        wr_onehot[wr_idx] = 1'b1;
        // Validity as it will be after this cycle's write, so a write and a
        // start in the same cycle behave as write-then-start.
        all_valid_nxt = (&(key_vld_q  | (key_wr  ? wr_onehot : '0))) &&
                        (&(data_vld_q | (data_wr ? wr_onehot : '0)));
    end

    riscv_aes_ctrl_fsm u_ctrl_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_req),
        .all_valid_i   (all_valid_nxt),
        .core_done_i   (core_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .core_start_o  (core_start_o),
        .err_invalid_o (err_invalid_set),
        .capture_o     (capture)
    );

    // Status bits: W1C clears first, hardware set events win.
    always_comb begin
        done_nxt    = done_q;
        err_inv_nxt = err_inv_q;
        err_wb_nxt  = err_wb_q;
        irq_en_nxt  = irq_en_q;
        if (ctrl_wr) begin
            if (wdata_i[CTRL_DONE])        done_nxt    = 1'b0;
            if (wdata_i[CTRL_ERR_INVALID]) err_inv_nxt = 1'b0;
            if (wdata_i[CTRL_ERR_WR_BUSY]) err_wb_nxt  = 1'b0;
            irq_en_nxt = wdata_i[CTRL_IRQ_EN];
        end
        if (capture)         done_nxt    = 1'b1;
        if (err_invalid_set) err_inv_nxt = 1'b1;
        if (wr_busy_err)     err_wb_nxt  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            err_inv_q <= 1'b0;
            err_wb_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            done_q    <= done_nxt;
            err_inv_q <= err_inv_nxt;
            err_wb_q  <= err_wb_nxt;
            irq_en_q  <= irq_en_nxt;
            // Registered from the next-state values so irq_o always equals
            // the visible done_sticky AND irq_en.
            irq_o     <= done_nxt && irq_en_nxt;
        end
    end

    // Key storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) key_q[i] <= '0;
            key_vld_q <= '0;
        end else begin
`ifdef AES_KEY_ZEROIZE_EN
            if (capture) begin
                for (int i = 0; i < NUM_WORDS; i++) key_q[i] <= '0;
                key_vld_q <= '0;
            end else
`endif
            if (key_wr) begin
                key_q[wr_idx]     <= wdata_i;
                key_vld_q[wr_idx] <= 1'b1;
            end
        end
    end

    // Data and result storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                data_q[i]   <= '0;
                result_q[i] <= '0;
            end
            data_vld_q <= '0;
        end else begin
            if (data_wr) begin
                data_q[wr_idx]     <= wdata_i;
                data_vld_q[wr_idx] <= 1'b1;
            end
            if (capture) begin
                for (int i = 0; i < NUM_WORDS; i++)
                    result_q[i] <= core_result_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read path
    always_comb begin
        status_word                   = '0;
        status_word[CTRL_BUSY]        = busy_o;
        status_word[CTRL_DONE]        = done_q;
        status_word[CTRL_ERR_INVALID] = err_inv_q;
        status_word[CTRL_ERR_WR_BUSY] = err_wb_q;
        status_word[CTRL_IRQ_EN]      = irq_en_q;

        rd_idx  = raddr_i[IDX_W-1:0];
        rd_word = '0;
        if (int'(raddr_i) < data_offset(NUM_WORDS))
            rd_word = test_en_i ? key_q[rd_idx] : '0;
        else if (int'(raddr_i) < result_offset(NUM_WORDS))
            rd_word = data_q[rd_idx];
        else if (int'(raddr_i) < ctrl_offset(NUM_WORDS))
            rd_word = result_q[rd_idx];
        else if (int'(raddr_i) == ctrl_offset(NUM_WORDS))
            rd_word = status_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_o <= '0;
        else        rdata_o <= rd_word;
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_core_bus
        assign core_key_o [g*DATA_WIDTH +: DATA_WIDTH] = key_q[g];
        assign core_data_o[g*DATA_WIDTH +: DATA_WIDTH] = data_q[g];
    end

endmodule

// File: tb/tb_riscv_aes_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_riscv_aes_reg_bank
// Directed scenarios followed by random traffic, every cycle compared against
// a behavioural model of the register bank held in arrays.
// -----------------------------------------------------------------------------
module tb_riscv_aes_reg_bank;

    localparam int DW   = 32;
    localparam int NW   = 4;
    localparam int AW   = 4;
    localparam int BW   = DW * NW;
    localparam int CTRL = 3 * NW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          test_en_i;
    logic [AW-1:0] waddr_i;
    logic [DW-1:0] wdata_i;
    logic          wen_i;
    logic [AW-1:0] raddr_i;
    logic [DW-1:0] rdata_o;
    logic          aes_start_i;
    logic          busy_o, done_o, irq_o;
    logic [BW-1:0] core_key_o, core_data_o;
    logic          core_start_o;
    logic          core_done_i;
    logic [BW-1:0] core_result_i;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    riscv_aes_reg_bank #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .test_en_i     (test_en_i),
        .waddr_i       (waddr_i),
        .wdata_i       (wdata_i),
        .wen_i         (wen_i),
        .raddr_i       (raddr_i),
        .rdata_o       (rdata_o),
        .aes_start_i   (aes_start_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .irq_o         (irq_o),
        .core_key_o    (core_key_o),
        .core_data_o   (core_data_o),
        .core_start_o  (core_start_o),
        .core_done_i   (core_done_i),
        .core_result_i (core_result_i)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_key [NW];
    logic [DW-1:0] m_data[NW];
    logic [DW-1:0] m_res [NW];
    bit            m_kv  [NW];
    bit            m_dv  [NW];
    int            m_mode;            // 0 idle, 1 running, 2 done cycle
    bit            m_done, m_einv, m_ewb, m_irqen;
    bit            e_cstart, e_done;
    logic [DW-1:0] e_rdata;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NW; i++) begin
            m_key[i] = '0; m_data[i] = '0; m_res[i] = '0;
            m_kv[i] = 0; m_dv[i] = 0;
        end
        m_mode = 0;
        m_done = 0; m_einv = 0; m_ewb = 0; m_irqen = 0;
        e_cstart = 0; e_done = 0; e_rdata = '0;
    endtask

    function automatic logic [DW-1:0] m_read(input int a);
        logic [DW-1:0] v = '0;
        if (a < NW)            v = test_en_i ? m_key[a] : '0;
        else if (a < 2 * NW)   v = m_data[a - NW];
        else if (a < 3 * NW)   v = m_res[a - 2 * NW];
        else if (a == CTRL) begin
            v[0] = (m_mode == 1);
            v[1] = m_done;
            v[2] = m_einv;
            v[3] = m_ewb;
            v[4] = m_irqen;
        end
        return v;
    endfunction

    // Effect of one rising edge given the inputs currently applied.
    task automatic m_edge();
        int a;
        bit start, running, allv;
        e_rdata  = m_read(int'(raddr_i));
        running  = (m_mode == 1);
        start    = aes_start_i;
        e_cstart = 0;
        e_done   = 0;
        if (wen_i) begin
            a = int'(waddr_i);
            if (a < 2 * NW) begin
                if (running) m_ewb = 1;
                else if (a < NW) begin m_key[a] = wdata_i; m_kv[a] = 1; end
                else begin m_data[a - NW] = wdata_i; m_dv[a - NW] = 1; end
            end else if (a == CTRL) begin
                if (wdata_i[1]) m_done = 0;
                if (wdata_i[2]) m_einv = 0;
                if (wdata_i[3]) m_ewb  = 0;
                m_irqen = wdata_i[4];
                if (wdata_i[5]) start = 1;
            end
        end
        case (m_mode)
            0: if (start) begin
                allv = 1;
                for (int i = 0; i < NW; i++) allv = allv & m_kv[i] & m_dv[i];
                if (allv) begin m_mode = 1; e_cstart = 1; end
                else m_einv = 1;
            end
            1: if (core_done_i) begin
                for (int i = 0; i < NW; i++) m_res[i] = core_result_i[i*DW +: DW];
                m_done = 1; m_mode = 2; e_done = 1;
`ifdef AES_KEY_ZEROIZE_EN
                for (int i = 0; i < NW; i++) begin m_key[i] = '0; m_kv[i] = 0; end
`endif
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all();
        logic [BW-1:0] ek, ed;
        for (int i = 0; i < NW; i++) begin
            ek[i*DW +: DW] = m_key[i];
            ed[i*DW +: DW] = m_data[i];
        end
        chk("busy",       busy_o,       m_mode == 1);
        chk("done",       done_o,       e_done);
        chk("core_start", core_start_o, e_cstart);
        chk("irq",        irq_o,        m_done & m_irqen);
        chk("rdata",      rdata_o,      e_rdata);
        chk("core_key",   core_key_o,   ek);
        chk("core_data",  core_data_o,  ed);
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        wen_i = 1; waddr_i = AW'(a); wdata_i = d;
        step();
        wen_i = 0;
    endtask

    task automatic rd(input int a);
        raddr_i = AW'(a);
        step();
    endtask

    task automatic do_reset();
        rst_n = 0;
        m_reset();
        #2;
        chk("rst_busy",  busy_o,       0);
        chk("rst_done",  done_o,       0);
        chk("rst_start", core_start_o, 0);
        chk("rst_irq",   irq_o,        0);
        chk("rst_rdata", rdata_o,      0);
        chk("rst_key",   core_key_o,   0);
        chk("rst_data",  core_data_o,  0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; test_en_i = 0; waddr_i = '0; wdata_i = '0; wen_i = 0;
        raddr_i = '0; aes_start_i = 0; core_done_i = 0; core_result_i = '0;
        #1;
        do_reset();

        // Load a full block and start it.
        for (int i = 0; i < NW; i++) wr(i, DW'(i));
        for (int i = 0; i < NW; i++) wr(NW + i, DW'(32'h10 + i));
        aes_start_i = 1;
        step();
        aes_start_i = 0;
        chk("start_pulse", core_start_o, 1);
        chk("start_busy",  busy_o,       1);
        chk("start_key",   core_key_o,   128'h00000003_00000002_00000001_00000000);
        step();
        chk("start_single", core_start_o, 0);

        // Write while running, then complete.
        wr(NW, 32'hDEAD);
        core_result_i = {NW{32'hA5A5A5A5}};
        core_done_i   = 1;
        step();
        core_done_i = 0;
        chk("done_pulse", done_o, 1);
        step();
        chk("done_single", done_o, 0);
        rd(NW);
        chk("busy_wr_dropped", rdata_o, 32'h10);
        rd(CTRL);
        chk("err_wr_busy", rdata_o[3], 1);
        rd(2 * NW);
        chk("result_word", rdata_o, 32'hA5A5A5A5);
        wr(2 * NW, 32'h1234);
        rd(2 * NW);
        chk("result_ro", rdata_o, 32'hA5A5A5A5);

        // Interrupt: enable, run an op via CTRL start bit, then clear done.
        wr(CTRL, 32'h1E);
        chk("irq_cleared", irq_o, 0);
        wr(CTRL, 32'h30);
        chk("ctrl_start", core_start_o, 1);
        core_done_i = 1;
        step();
        core_done_i = 0;
        step();
        chk("irq_set", irq_o, 1);
        wr(CTRL, 32'h2);
        chk("irq_w1c", irq_o, 0);

        // Reset in the middle of a run; a late done must be ignored.
        aes_start_i = 1;
        step();
        aes_start_i = 0;
        chk("run_again", busy_o, 1);
        do_reset();
        core_result_i = {NW{32'h5A5A5A5A}};
        core_done_i = 1;
        step();
        core_done_i = 0;
        rd(2 * NW);
        chk("late_done_ignored", rdata_o, 0);
        chk("idle_after_rst", busy_o, 0);

        // Start with one data word missing.
        for (int i = 0; i < NW; i++) wr(i, $urandom);
        for (int i = 0; i < NW - 1; i++) wr(NW + i, $urandom);
        aes_start_i = 1;
        step();
        aes_start_i = 0;
        chk("invalid_no_start", core_start_o, 0);
        rd(CTRL);
        chk("status_invalid", rdata_o, 32'h4);

        // Write and start in the same cycle completes the block.
        wr(CTRL, 32'h4);
        wen_i = 1; waddr_i = AW'(2 * NW - 1); wdata_i = 32'h77;
        aes_start_i = 1;
        step();
        wen_i = 0; aes_start_i = 0;
        chk("wr_then_start", core_start_o, 1);
        core_done_i = 1;
        step();
        core_done_i = 0;
        step();

`ifdef AES_KEY_ZEROIZE_EN
        test_en_i = 1;
        rd(0);
        chk("zeroize_key0", rdata_o, 0);
        test_en_i = 0;
        aes_start_i = 1;
        step();
        aes_start_i = 0;
        rd(CTRL);
        chk("zeroize_restart_invalid", rdata_o[2], 1);
`endif

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            wen_i         = ($urandom_range(0, 1) == 1);
            waddr_i       = AW'($urandom_range(0, 15));
            wdata_i       = $urandom;
            raddr_i       = AW'($urandom_range(0, 15));
            test_en_i     = ($urandom_range(0, 1) == 1);
            aes_start_i   = ($urandom_range(0, 7) == 0);
            core_done_i   = ($urandom_range(0, 3) == 0);
            core_result_i = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
